// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the 16-channel mux scan controller.
package mux16_scan_ctrl_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/mux16_scan_ctrl_next_ch.sv
// Finds the lowest enabled channel strictly above the current index.
// With from_start set, the search covers every channel (current treated as -1).
module scan_next_ch
    import mux16_scan_ctrl_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             from_start,
    output logic [SEL_W-1:0] next,
    output logic             none
);

    logic [N_CH-1:0] cand;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (from_start || (SEL_W'(gi) > cur));
        end
    endgenerate

    // Walk downwards so the lowest qualifying channel is the last one written.
    always_comb begin
        next = '0;
        none = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand[k]) begin
                next = SEL_W'(k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for an external 16:1 bit mux: steps the select across the
// enabled channels in ascending order and captures each settled bit.
module mux16_scan_ctrl
    import mux16_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  en_mask,
    input  logic             y_in,
    output logic [SEL_W-1:0] s_out,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  result
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t            state_reg,  state_next;
    logic [N_CH-1:0]   mask_reg,   mask_next;
    logic [SEL_W-1:0]  sel_reg,    sel_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [N_CH-1:0]   result_reg, result_next;
    logic              done_reg,   done_next;

    logic [N_CH-1:0]   search_mask;
    logic [SEL_W-1:0]  found_ch;
    logic              found_none;

    // In IDLE the live mask is searched from the bottom; in SCAN the latched copy above sel.
    assign search_mask = (state_reg == ST_IDLE) ? en_mask : mask_reg;

    scan_next_ch u_next_ch (
        .mask       (search_mask),
        .cur        (sel_reg),
        .from_start (state_reg == ST_IDLE),
        .next       (found_ch),
        .none       (found_none)
    );

    always_comb begin
        state_next  = state_reg;
        mask_next   = mask_reg;
        sel_next    = sel_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mask_next   = en_mask;
                    result_next = '0;
                    cnt_next    = '0;
                    if (found_none) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_SCAN;
                        sel_next   = found_ch;
                    end
                end
            end
            ST_SCAN: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next             = '0;
                    result_next[sel_reg] = y_in;
                    if (found_none) begin
                        state_next = ST_IDLE;
                        sel_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        sel_next = found_ch;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                sel_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            mask_reg   <= '0;
            sel_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mask_reg   <= mask_next;
            sel_reg    <= sel_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    assign s_out  = sel_reg;
    assign busy   = (state_reg == ST_SCAN);
    assign done   = done_reg;
    assign result = result_reg;

endmodule
